stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit registered stream multiplexer, replacing the fixed 1-bit 2:1 mux in the datapath. It merges NUM_CH valid/ready input streams onto one registered output stream. MODE selects either external selection (Sel port) or round-robin arbitration. The output stage is one register, so latency is 1 cycle, and the block sustains full throughput of 1 beat/cycle.

Parameters:
W, 8, data width per channel in bits (>=1)
NUM_CH, 4, number of input channels (2..16)
SEL_W, 2, select/index width; must equal ceil(log2(NUM_CH))
MODE, 0, 0 = external select via Sel; 1 = round-robin arbitration (Sel ignored)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
A  in  NUM_CH*W  input data, flattened; channel i occupies bits [i*W +: W]
A_valid  in  NUM_CH  per-channel valid
A_ready  out  NUM_CH  per-channel ready (one-hot or zero)
Sel  in  SEL_W  channel select, used only when MODE=0
S  out  W  output data (registered)
S_valid  out  1  output valid (registered)
S_ready  in  1  downstream ready
S_ch  out  SEL_W  index of the channel that produced the current S (registered)
sel_err  out  1  sticky flag: set when Sel >= NUM_CH while MODE=0

Behaviour:
- Reset (rst_n=0 at a rising edge): S=0, S_valid=0, S_ch=0, sel_err=0, round-robin pointer=0. A_ready stays 0 while rst_n=0.
- Load enable: load = !S_valid || S_ready. The output register accepts a beat only when load=1.
- Grant, MODE=0: grant channel g=Sel if Sel<NUM_CH and A_valid[Sel]=1. Otherwise there is no grant.
- Grant, MODE=1: starting at pointer p, grant the first channel i in p, p+1, ... (mod NUM_CH) with A_valid[i]=1. Otherwise there is no grant.
- A_ready[g] = load && grant && rst_n. All other A_ready bits are 0. A_ready is combinational from A_valid, Sel, S_valid, S_ready and the pointer.
- Transfer: on a clock edge with a grant and load=1, S <= A[g], S_ch <= g, S_valid <= 1.
  - In MODE=1 only, the pointer is set to (g+1) mod NUM_CH; wrap from NUM_CH-1 goes to 0.
- No grant and load=1: S_valid <= 0. S and S_ch hold their values (don't-care while S_valid=0). Pointer holds.
- Backpressure: S_valid=1 and S_ready=0 means S, S_ch and S_valid hold, all A_ready=0, and the pointer holds.
- Simultaneous: with S_valid=1, S_ready=1 and a new grant, the current beat drains and the new beat loads in the same edge, giving no bubble.
- Output stability: once S_valid=1, S and S_ch must not change until S_ready=1 is sampled.
- Out-of-range Sel (MODE=0, Sel>=NUM_CH): no grant and sel_err <= 1 on that edge. sel_err clears only on reset.
- Sel change mid-stream (MODE=0): takes effect on the next grant evaluation. A beat already in S is unaffected.
- Reset mid-operation: an in-flight S beat is discarded (S_valid=0 after the edge). No A_ready is asserted during reset, so no input beat is consumed.
- Fairness (MODE=1): with all channels continuously valid and S_ready=1, grants rotate 0,1,...,NUM_CH-1,0,...; no channel waits more than NUM_CH-1 accepted beats.
- Input data is not registered on the input side. Only the output stage is registered.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all A_valid=1 -> S=0, S_valid=0, S_ch=0, sel_err=0, A_ready=0000 throughout.
- MODE=0 select: W=8, NUM_CH=4, A={8'h44,8'h33,8'h22,8'h11}, all valid, Sel=2, S_ready=1 -> A_ready=0100; after 1 cycle S=8'h33, S_ch=2, S_valid=1. Switch Sel=0 -> next beat S=8'h11, S_ch=0.
- MODE=0 invalid select: NUM_CH=3, SEL_W=2, Sel=3 -> A_ready=000, S_valid falls to 0, sel_err=1 and stays 1 after Sel returns to 0, until rst_n=0.
- MODE=1 rotation: NUM_CH=4, all A_valid=1, S_ready=1 for 8 cycles -> S_ch sequence 0,1,2,3,0,1,2,3; S_valid=1 every cycle after the first.
- MODE=1 sparse plus wrap: only A_valid[3] and A_valid[1] asserted, pointer=2 -> grant 3, then 1, then 3; pointer wraps 3 -> 0 correctly.
- Backpressure: S_valid=1 with S=8'hAA, hold S_ready=0 for 4 cycles while inputs change -> S stays 8'hAA, S_ch holds, A_ready=0000. S_ready=1 -> the next beat loads on the same edge the current one drains, with no bubble cycle.

Source files
------------

// File: rtl/stream_mux_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel, W-bit valid/ready stream multiplexer with a single
//               registered output stage (1-cycle latency, 1 beat/cycle).
//               MODE=0 picks the channel named by Sel; MODE=1 arbitrates
//               round-robin starting at an internal pointer.
// Ports       : clk      - rising-edge clock
//               rst_n    - synchronous active-low reset
//               A        - flattened input data, channel i at [i*W +: W]
//               A_valid  - per-channel valid
//               A_ready  - per-channel ready (one-hot or zero, combinational)
//               Sel      - channel select (MODE=0 only)
//               S        - registered output data
//               S_valid  - registered output valid
//               S_ready  - downstream ready
//               S_ch     - channel index that produced S
//               sel_err  - sticky out-of-range Sel flag (MODE=0)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int W      = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_CH*W-1:0] A,
    input  logic [NUM_CH-1:0]   A_valid,
    output logic [NUM_CH-1:0]   A_ready,
    input  logic [SEL_W-1:0]    Sel,
    output logic [W-1:0]        S,
    output logic                S_valid,
    input  logic                S_ready,
    output logic [SEL_W-1:0]    S_ch,
    output logic                sel_err
);

    // One extra bit so NUM_CH itself is representable when it is a power of 2.
    localparam logic [SEL_W:0]   c_num_ch = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_last   = SEL_W'(NUM_CH-1);

    logic [W-1:0]     r_s;
    logic             r_s_valid;
    logic [SEL_W-1:0] r_s_ch;
    logic             r_sel_err;

    logic             w_load;
    logic             w_grant;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [W-1:0]     w_data;
    logic             w_sel_oor;

    // The output register can take a beat when empty or draining this edge.
    assign w_load    = !r_s_valid || S_ready;
    assign w_sel_oor = (MODE == 0) && ({1'b0, Sel} >= c_num_ch);

    generate
        if (MODE == 0) begin : g_mode_sel
            // Loop over legal channels only, so an out-of-range Sel simply
            // matches nothing and the grant index never leaves [0, NUM_CH).
            always_comb begin
                w_grant   = 1'b0;
                w_gnt_idx = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (Sel == SEL_W'(i)) begin
                        w_grant   = A_valid[i];
                        w_gnt_idx = SEL_W'(i);
                    end
                end
            end
        end else begin : g_mode_rr
            logic [SEL_W-1:0] r_ptr;

            // Scan NUM_CH positions starting at the pointer; first valid wins.
            always_comb begin
                int j;
                j         = 0;
                w_grant   = 1'b0;
                w_gnt_idx = '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    j = int'(r_ptr) + k;
                    if (j >= NUM_CH) begin
                        j = j - NUM_CH;
                    end
                    if (!w_grant && A_valid[j]) begin
                        w_grant   = 1'b1;
                        w_gnt_idx = SEL_W'(j);
                    end
                end
            end

            // Pointer only moves on an accepted beat, to just past the winner.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ptr <= '0;
                end else if (w_load && w_grant) begin
                    r_ptr <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
                end
            end
        end
    endgenerate

    assign w_data = A[int'(w_gnt_idx)*W +: W];

    always_comb begin
        A_ready = '0;
        if (rst_n && w_load && w_grant) begin
            A_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_s_valid <= 1'b0;
            r_s_ch    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_sel_oor) begin
                r_sel_err <= 1'b1;
            end
            if (w_load) begin
                if (w_grant) begin
                    r_s       <= w_data;
                    r_s_ch    <= w_gnt_idx;
                    r_s_valid <= 1'b1;
                end else begin
                    // Data and channel hold; they are meaningless while invalid.
                    r_s_valid <= 1'b0;
                end
            end
        end
    end

    assign S       = r_s;
    assign S_valid = r_s_valid;
    assign S_ch    = r_s_ch;
    assign sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr. Two instances:
//               MODE=0 with 3 channels (so Sel=3 is out of range) and
//               MODE=1 with 4 channels. A driver issues random traffic,
//               predicts grants from the selection rules and queues the
//               expected output beats; a monitor checks the output side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] done  = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar d = 0; d < 2; d++) begin : g_dut
        localparam int N    = (d == 0) ? 3 : 4;
        localparam int M    = d;
        localparam int NCYC = 2500;

        logic           rst_n;
        logic [N*8-1:0] a;
        logic [N-1:0]   av;
        logic [N-1:0]   ar;
        logic [1:0]     sel;
        logic [7:0]     s;
        logic           sv;
        logic           srdy;
        logic [1:0]     sch;
        logic           serr;

        // Expected contents of the output register: {channel, data}.
        logic [15:0]    q[$];

        stream_mux_rr #(
            .W      (8),
            .NUM_CH (N),
            .SEL_W  (2),
            .MODE   (M)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .A       (a),
            .A_valid (av),
            .A_ready (ar),
            .Sel     (sel),
            .S       (s),
            .S_valid (sv),
            .S_ready (srdy),
            .S_ch    (sch),
            .sel_err (serr)
        );

        // Driver + reference model: inputs change at posedge+1, the
        // grant prediction is formed at posedge+2, and its effect on the
        // model is committed just after the following edge.
        initial begin : drv
            int          ptr;
            int          g;
            int          i;
            bit          gok;
            bit          load;
            bit          m_err;
            bit          prev_rst;
            bit          prev_xfer;
            bit          prev_oor;
            logic [7:0]  prev_data;
            int          prev_ch;
            logic [N-1:0] e;
            logic [31:0] r;

            rst_n     = 1'b0;
            a         = '0;
            av        = '1;
            sel       = 2'd0;
            srdy      = 1'b1;
            ptr       = 0;
            m_err     = 1'b0;
            prev_rst  = 1'b1;
            prev_xfer = 1'b0;
            prev_oor  = 1'b0;
            prev_data = '0;
            prev_ch   = 0;

            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #2;
                chk($sformatf("d%0d reset A_ready", d), 32'(ar), 32'd0);
                chk($sformatf("d%0d reset S_valid", d), 32'(sv), 32'd0);
                chk($sformatf("d%0d reset S", d), 32'(s), 32'd0);
                chk($sformatf("d%0d reset S_ch", d), 32'(sch), 32'd0);
                chk($sformatf("d%0d reset sel_err", d), 32'(serr), 32'd0);
            end

            for (int c = 0; c < NCYC; c++) begin
                @(posedge clk);
                #1;
                if (prev_rst) begin
                    q.delete();
                    ptr   = 0;
                    m_err = 1'b0;
                    chk($sformatf("d%0d post-reset S", d), 32'(s), 32'd0);
                    chk($sformatf("d%0d post-reset S_ch", d), 32'(sch), 32'd0);
                end else begin
                    if (prev_xfer) begin
                        q.push_back({prev_ch[7:0], prev_data});
                        if (M == 1) begin
                            ptr = (prev_ch + 1) % N;
                        end
                    end
                    if (prev_oor) begin
                        m_err = 1'b1;
                    end
                end
                chk($sformatf("d%0d sel_err", d), 32'(serr), 32'(m_err));

                r     = $urandom();
                rst_n = (r[6:0] != 7'd0);
                r     = $urandom();
                a     = r[N*8-1:0];
                r     = $urandom();
                av    = r[N-1:0] | r[N+7:8];
                r     = $urandom();
                sel   = r[1:0];
                if (M == 0 && sel == 2'd3 && r[5:2] != 4'd0) begin
                    sel = 2'd1;
                end
                srdy  = (r[9:8] != 2'd0);
                if (c >= 400 && c < 440) begin
                    rst_n = 1'b1;
                    av    = '1;
                    srdy  = 1'b1;
                end
                if (c >= 600 && c < 610) begin
                    rst_n = 1'b1;
                    srdy  = 1'b0;
                end
                #1;

                load = (q.size() == 0) || srdy;
                gok  = 1'b0;
                g    = 0;
                if (M == 0) begin
                    g = int'(sel);
                    if (g < N) begin
                        gok = av[g];
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        i = (ptr + k) % N;
                        if (!gok && av[i]) begin
                            gok = 1'b1;
                            g   = i;
                        end
                    end
                end
                e = '0;
                if (rst_n && load && gok) begin
                    e[g] = 1'b1;
                end
                chk($sformatf("d%0d A_ready", d), 32'(ar), 32'(e));

                prev_rst  = !rst_n;
                prev_xfer = rst_n && load && gok;
                prev_ch   = g;
                prev_data = gok ? a[g*8 +: 8] : 8'h00;
                prev_oor  = (M == 0) && (int'(sel) >= N);
            end
            done[d] = 1'b1;
        end

        // Monitor: the register must be valid exactly when the model holds a
        // beat, must show that beat unchanged until it drains.
        initial begin : mon
            logic [15:0] h;
            while (!done[d]) begin
                @(negedge clk);
                chk($sformatf("d%0d S_valid", d), 32'(sv), 32'(q.size() != 0));
                if (sv && q.size() != 0) begin
                    h = q[0];
                    chk($sformatf("d%0d S", d), 32'(s), 32'(h[7:0]));
                    chk($sformatf("d%0d S_ch", d), 32'(sch), 32'(h[9:8]));
                    if (srdy) begin
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : fin
        wait (done == 2'b11);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not complete, got done=%b expected 11", done);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
